ctrl_seq_unit: RTL

Parametrised multi-cycle stage sequencer for the 16-bit RISC core. It steps a one-hot stage vector through fetch, decode, register-read, ALU, write-back and memory, each stage lasting one cycle. Beyond a fixed stage ring it adds an idle state, a run gate, stall and flush, per-instruction stage skipping latched at decode, and a configurable register-read strobe mask. It sits between the datapath stage blocks and the top level, and drives every per-stage enable.

---
 rtl/ctrl_seq_unit_if.sv | 34 +++
 rtl/ctrl_seq_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/ctrl_seq_unit_if.sv
// Stage-sequencer control bundle: run/stall/flush/skip requests in,
// stage enables, status and performance counters out.
interface ctrl_seq_unit_if #(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  i_run;
    logic                  i_stall;
    logic                  i_flush;
    logic [NUM_STAGES-1:0] i_skip_mask;
    logic [NUM_STAGES-1:0] o_stage_en;
    logic [IDX_W-1:0]      o_stage_idx;
    logic                  o_enrgrd;
    logic                  o_busy;
    logic                  o_instr_done;
    logic [CNT_W-1:0]      o_retire_cnt;
    logic [CNT_W-1:0]      o_stall_cnt;

    // Top-level / control side
    modport master (
        output i_run, i_stall, i_flush, i_skip_mask,
        input  o_stage_en, o_stage_idx, o_enrgrd, o_busy, o_instr_done,
               o_retire_cnt, o_stall_cnt
    );

    // Sequencer side
    modport slave (
        input  i_run, i_stall, i_flush, i_skip_mask,
        output o_stage_en, o_stage_idx, o_enrgrd, o_busy, o_instr_done,
               o_retire_cnt, o_stall_cnt
    );
endinterface

// File: rtl/ctrl_seq_unit.sv
// ctrl_seq_unit: one-hot multi-cycle stage sequencer for the 16-bit core.
// Steps fetch..memory with idle, run gate, stall, flush and per-instruction
// stage skipping latched at decode.
// Optional feature macro: CTRL_SEQ_PERF_EN (retire / stall counters).
module ctrl_seq_unit #(
    parameter int unsigned           NUM_STAGES = 6,
    parameter int unsigned           DEC_STAGE  = 1,
    parameter logic [NUM_STAGES-1:0] RGRD_MASK  = 6'b010100,
    parameter int unsigned           CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    ctrl_seq_unit_if.slave   bus
);
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [NUM_STAGES-1:0] STAGE0 = NUM_STAGES'(1);

    logic [NUM_STAGES-1:0] state;      // one-hot, all-zero = IDLE
    logic [NUM_STAGES-1:0] skip;
    logic [NUM_STAGES-1:0] eff_skip;
    logic [NUM_STAGES-1:0] next_onehot;
    int unsigned           cur_k;
    logic                  busy;
    logic                  at_dec;
    logic                  found;
    logic                  instr_done;

    assign busy   = |state;
    assign at_dec = state[DEC_STAGE];

    // Binary index of the active stage (0 when idle)
    always_comb begin
        cur_k = 0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (state[i]) cur_k = i;
        end
    end

    // Effective skip mask and search for the next non-skipped stage above the current one
    always_comb begin
        eff_skip = at_dec ? bus.i_skip_mask : skip;
        for (int unsigned i = 0; i <= DEC_STAGE; i++) begin
            eff_skip[i] = 1'b0;
        end
        found       = 1'b0;
        next_onehot = '0;
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            if (!found && (j > cur_k) && !eff_skip[j]) begin
                found          = 1'b1;
                next_onehot[j] = 1'b1;
            end
        end
    end

    assign instr_done = busy & ~found & ~bus.i_stall & ~bus.i_flush;

    // Stage/skip state: reset > flush > stall > advance; completion restarts or idles
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= '0;
            skip  <= '0;
        end else if (!busy) begin
            if (bus.i_run) state <= STAGE0;
        end else if (bus.i_flush || (!bus.i_stall && !found)) begin
            state <= bus.i_run ? STAGE0 : '0;
            skip  <= '0;
        end else if (!bus.i_stall) begin
            state <= next_onehot;
            if (at_dec) skip <= eff_skip;
        end
    end

    assign bus.o_stage_en   = state;
    assign bus.o_stage_idx  = IDX_W'(cur_k);
    assign bus.o_enrgrd     = |(state & RGRD_MASK);
    assign bus.o_busy       = busy;
    assign bus.o_instr_done = instr_done;

`ifdef CTRL_SEQ_PERF_EN
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Retire counter wraps; stall counter saturates at all-ones
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (instr_done) retire_cnt <= retire_cnt + CNT_W'(1);
            if (busy && bus.i_stall && !bus.i_flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.o_retire_cnt = retire_cnt;
    assign bus.o_stall_cnt  = stall_cnt;
`else
    assign bus.o_retire_cnt = '0;
    assign bus.o_stall_cnt  = '0;
`endif
endmodule
